// File: rtl/imem_loader_pkg.sv
// Shared processor definitions: loader state encoding and instruction-memory geometry,
// also imported by the processor and the instruction memory.
package imem_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLen  = 3'd1,
        StData = 3'd2,
        StCsum = 3'd3,
        StDone = 3'd4,
        StErr  = 3'd5
    } state_e;

    // Only the length/payload/checksum phases talk to the host.
    function automatic logic is_active(input state_e s);
        return (s == StLen) || (s == StData) || (s == StCsum);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host-stream, instruction-memory write and status signals of the loader.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
    );

endinterface

// File: rtl/loader_csum.sv
// Modular running sum of the image payload; clear wins over enable.
module loader_csum
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_sum
);

    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed image into instruction memory and holds the
// processor in reset until a complete, verified image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    localparam int unsigned CntW = ADDR_W + 1;
    // Wide enough to hold both the raw length word and 2^ADDR_W without truncation.
    localparam int unsigned CmpW = ((DATA_W > CntW) ? DATA_W : CntW) + 1;
    localparam logic [CmpW-1:0] MaxLen = CmpW'(2 ** ADDR_W);

    state_e            r_state;
    state_e            w_state_next;

    logic [CntW-1:0]   r_len;
    logic [CntW-1:0]   r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_xfer;
    logic              w_start_ok;
    logic [CmpW-1:0]   w_len_ext;
    logic              w_len_bad;
    logic              w_last;
    logic              w_sum_ok;
    logic              w_sum_en;
    logic              w_sum_clr;
    logic [DATA_W-1:0] w_sum;

    logic              w_in_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_error;
    logic              w_cpu_reset;

    assign w_xfer     = bus.in_valid && w_in_ready;
    assign w_start_ok = bus.start && !is_active(r_state);
    assign w_len_ext  = CmpW'(bus.in_data);
    assign w_len_bad  = (w_len_ext == '0) || (w_len_ext > MaxLen);
    assign w_last     = (r_cnt + CntW'(1)) == r_len;
    assign w_sum_ok   = bus.in_data == w_sum;
    assign w_sum_en   = (r_state == StData) && w_xfer;
    assign w_sum_clr  = reset || w_start_ok;

    loader_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk    (clk),
        .i_clr  (w_sum_clr),
        .i_en   (w_sum_en),
        .i_data (bus.in_data),
        .o_sum  (w_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone, StErr: begin
                if (bus.start) w_state_next = StLen;
            end
            StLen: begin
                if (w_xfer) w_state_next = w_len_bad ? StErr : StData;
            end
            StData: begin
                if (w_xfer && w_last) w_state_next = StCsum;
            end
            StCsum: begin
                if (w_xfer) w_state_next = w_sum_ok ? StDone : StErr;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        w_cpu_reset = 1'b1;
        unique case (r_state)
            StLen, StData, StCsum: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            StDone: begin
                w_done      = 1'b1;
                w_cpu_reset = 1'b0;
            end
            StErr:   w_error = 1'b1;
            default: ;
        endcase
    end

    // Write port is registered: the strobe lands one cycle after the payload transfer and
    // address/data hold their last values between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_cnt <= '0;
            end
            if ((r_state == StLen) && w_xfer && !w_len_bad) begin
                r_len <= w_len_ext[CntW-1:0];
            end
            if ((r_state == StData) && w_xfer) begin
                r_we    <= 1'b1;
                r_addr  <= r_cnt[ADDR_W-1:0];
                r_wdata <= bus.in_data;
                r_cnt   <= r_cnt + CntW'(1);
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.error      = w_error;
    assign bus.cpu_reset  = w_cpu_reset;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized load sessions checked against an image/checksum model and a
// memory model fed from the write port.
module tb_imem_loader;

    localparam int AW    = imem_loader_pkg::ADDR_W_DEF;
    localparam int DW    = imem_loader_pkg::DATA_W_DEF;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_loader #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] img [DEPTH];
    int            wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            ready_bad = 0;
    bit            mon_en    = 1'b0;
    bit            exp_active = 1'b0;

    // Instruction-memory model plus a check that the host is only offered in_ready mid-session.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.imem_we === 1'b1) begin
                mem[bus.imem_addr] = bus.imem_wdata;
                wr_addr_q.push_back(int'(bus.imem_addr));
                wr_data_q.push_back(bus.imem_wdata);
            end
            if (bus.in_ready !== exp_active) ready_bad++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input int maxgap);
        int t;
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        bus.in_valid = 1'b0;
        repeat (g) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        t = 0;
        while (!bus.in_ready && t < 20) begin
            tick();
            t++;
        end
        if (!bus.in_ready) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = DW'($urandom);
    endtask

    task automatic start_session();
        bus.start = 1'b1;
        tick();
        bus.start  = 1'b0;
        exp_active = 1'b1;
    endtask

    task automatic run_image(input string tag, input int len, input bit good, input int maxgap);
        logic [DW-1:0] sum;
        int            base;
        int            bad;
        sum = '0;
        for (int k = 0; k < len; k++) sum = sum + img[k];
        base = wr_addr_q.size();
        start_session();
        chk({tag, "_busy_len"}, 32'(bus.busy), 32'd1);
        send(DW'(len), maxgap);
        for (int k = 0; k < len; k++) send(img[k], maxgap);
        send(good ? sum : sum + DW'(1), maxgap);
        exp_active = 1'b0;
        chk({tag, "_done"}, 32'(bus.done), 32'(good));
        chk({tag, "_error"}, 32'(bus.error), 32'(!good));
        chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(!good));
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        repeat (2) tick();
        chk({tag, "_nwrites"}, 32'(wr_addr_q.size() - base), 32'(len));
        bad = 0;
        for (int i = 0; i < len && base + i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[base + i] != i || wr_data_q[base + i] !== img[i]) bad++;
            if (mem[i] !== img[i]) bad++;
        end
        chk({tag, "_contents"}, 32'(bad), 32'd0);
    endtask

    task automatic err_len(input string tag, input int len);
        int base;
        base = wr_addr_q.size();
        start_session();
        send(DW'(len), 0);
        exp_active = 1'b0;
        chk({tag, "_error"}, 32'(bus.error), 32'd1);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
        repeat (3) tick();
        chk({tag, "_nwrites"}, 32'(wr_addr_q.size() - base), 32'd0);
    endtask

    initial begin
        int base;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_imem_wdata", 32'(bus.imem_wdata), 32'd0);
        chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        img[0] = 16'h1111;
        img[1] = 16'h2222;
        img[2] = 16'h3333;
        run_image("basic", 3, 1'b1, 0);
        chk("hold_addr", 32'(bus.imem_addr), 32'd2);
        chk("hold_wdata", 32'(bus.imem_wdata), 32'h3333);

        run_image("badsum", 3, 1'b0, 0);
        img[0] = 16'hABCD;
        run_image("single", 1, 1'b1, 0);

        err_len("len0", 0);
        err_len("len1025", DEPTH + 1);

        for (int k = 0; k < DEPTH; k++) img[k] = DW'(k);
        run_image("full", DEPTH, 1'b1, 0);
        chk("full_last_addr", 32'(wr_addr_q[wr_addr_q.size() - 1]), 32'(DEPTH - 1));

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) img[k] = DW'($urandom);
            run_image("gaps4", 4, 1'b1, 4);
        end
        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(40, 1));
            for (int k = 0; k < len; k++) img[k] = DW'($urandom);
            run_image("rand", len, bit'($urandom_range(1, 0)), 2);
        end

        // Abort after two of five words; a start during DATA must not restart the count.
        for (int k = 0; k < 5; k++) img[k] = DW'($urandom);
        base = wr_addr_q.size();
        start_session();
        send(16'd5, 0);
        send(img[0], 0);
        bus.start = 1'b1;
        send(img[1], 0);
        bus.start    = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = img[2];
        tick();
        exp_active = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
        chk("abort_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("abort_imem_we", 32'(bus.imem_we), 32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (4) tick();
        chk("abort_nwrites", 32'(wr_addr_q.size() - base), 32'd2);
        chk("abort_addr1", 32'(wr_addr_q[wr_addr_q.size() - 1]), 32'd1);
        chk("abort_mem0", 32'(mem[0]), 32'(img[0]));
        chk("abort_mem1", 32'(mem[1]), 32'(img[1]));

        for (int k = 0; k < 4; k++) img[k] = DW'($urandom);
        run_image("after_abort", 4, 1'b1, 1);

        chk("ready_phase", 32'(ready_bad), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory address width (depth 2^ADDR_W words).
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a load session.
REQ-006 in_valid  input  1  host word valid.
REQ-007 in_data  input  DATA_W  host word (length, payload or checksum).
REQ-008 in_ready  output  1  loader accepts word this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  instruction-memory write address.
REQ-011 imem_wdata  output  DATA_W  instruction-memory write data.
REQ-012 cpu_reset  output  1  holds processor in reset; drives processor reset input.
REQ-013 busy  output  1  load session in progress.
REQ-014 done  output  1  image loaded and checksum matched.
REQ-015 error  output  1  bad length or checksum mismatch.

Function
REQ-016 States IDLE, LEN, DATA, CSUM, DONE, ERR; registered, one state per cycle max.
REQ-017 Transfer = in_valid && in_ready at rising clk; in_ready high only in LEN, DATA, CSUM; in_valid low stalls indefinitely, no timeout.
REQ-018 IDLE/DONE/ERR: start -> LEN, clears done, error, word counter and checksum; start ignored in LEN/DATA/CSUM.
REQ-019 LEN: transferred word L; L == 0 or L > 2^ADDR_W -> ERR; else latch L, -> DATA.
REQ-020 DATA: k-th transfer (k = 0..L-1) writes in_data to address k; sum <= (sum + in_data) mod 2^DATA_W.
REQ-021 Write latency: imem_we high exactly one cycle, the cycle after the transfer, with imem_addr/imem_wdata registered alongside; imem_we low otherwise.
REQ-022 Transfer of word k = L-1 -> CSUM; counter is ADDR_W+1 bits so L = 2^ADDR_W (1024) loads addresses 0..1023 without wrap.
REQ-023 CSUM: transferred word equal to sum (including the final DATA word) -> DONE, else -> ERR; checksum word is never written to memory.
REQ-024 busy high in LEN, DATA, CSUM; done high only in DONE; error high only in ERR.
REQ-025 cpu_reset high in every state except DONE; deasserts the cycle DONE is entered, reasserts when start leaves DONE.
REQ-026 imem_addr/imem_wdata hold last written values when imem_we low.

Reset
REQ-027 reset forces IDLE; in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, busy 0, done 0, error 0; counter and sum 0.
REQ-028 reset mid-session aborts without the pending write (imem_we 0 next cycle); words already written stay in memory.
REQ-029 reset has priority over start and any transfer in the same cycle.

Structure
REQ-030 State encoding and ADDR_W/DATA_W defaults live in the shared processor definitions header, also used by processor and instruction memory.
REQ-031 One sub-module, loader_csum: DATA_W modular accumulator with synchronous clear and enable; FSM, counter and write register stay in imem_loader.

Verification
REQ-032 Reset, start, stream L=3, 0x1111, 0x2222, 0x3333, checksum 0x6666 -> addresses 0..2 written once each, done=1, cpu_reset=0 the cycle after checksum transfer.
REQ-033 Same stream, checksum 0x6667 -> error=1, done=0, cpu_reset stays 1; start then valid L=1, 0xABCD, 0xABCD -> done=1.
REQ-034 L=0 and L=1025 -> ERR immediately after length transfer, no imem_we pulse.
REQ-035 L=1024, data = address, checksum 0xFE00 -> last write at address 1023, no wrap to 0, done=1.
REQ-036 Random in_valid gaps with L=4 -> exactly 4 imem_we pulses, correct addresses/data, in_ready never high in IDLE/DONE/ERR.
REQ-037 reset asserted after 2 of 5 data words -> IDLE, cpu_reset=1, no further writes; addresses 0..1 retain written values.
